// File: rtl/tour_length.sv
// Evaluates the closed-tour Euclidean length of a 64-vertex permutation and
// tracks the shortest tour seen since reset.
module tour_length (
    input  logic              clk,
    input  logic              rst,
    input  logic [63:0][31:0] xs,
    input  logic [63:0][31:0] ys,
    input  logic [63:0][31:0] path,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [31:0]       length,
    output logic [31:0]       best,
    output logic              improved
);

    typedef enum logic [2:0] {IDLE, LOAD, SQRT, ACC, DONE} state_t;

    state_t          state;
    logic [63:0][5:0] snap;
    logic [5:0]      edge_idx;
    logic [3:0]      step_cnt;
    logic [31:0]     acc;
    logic [31:0]     rad;
    logic [15:0]     root;
    logic [17:0]     rem;

    logic [5:0]      va, vb;
    logic [14:0]     xa, xb, ya, yb, dx, dy;
    logic [31:0]     radicand;
    logic [18:0]     shifted, divisor, trial;
    logic [31:0]     acc_sum;
    logic            unused_bits;

    // Edge endpoints wrap naturally through the 6-bit index, closing the tour.
    always_comb begin
        va       = snap[edge_idx];
        vb       = snap[edge_idx + 6'd1];
        xa       = xs[va][14:0];
        xb       = xs[vb][14:0];
        ya       = ys[va][14:0];
        yb       = ys[vb][14:0];
        dx       = (xa >= xb) ? (xa - xb) : (xb - xa);
        dy       = (ya >= yb) ? (ya - yb) : (yb - ya);
        radicand = ({17'd0, dx} * {17'd0, dx}) + ({17'd0, dy} * {17'd0, dy});
        shifted  = {rem[16:0], rad[31:30]};
        divisor  = {1'b0, root, 2'b01};
        trial    = shifted - divisor;
        acc_sum  = acc + {16'd0, root};
    end

    assign unused_bits = ^{xs, ys, path, trial[18], rem[17]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            snap     <= '0;
            edge_idx <= '0;
            step_cnt <= '0;
            acc      <= '0;
            rad      <= '0;
            root     <= '0;
            rem      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            improved <= 1'b0;
            length   <= '0;
            best     <= 32'hFFFF_FFFF;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        for (int i = 0; i < 64; i++) begin
                            snap[i] <= path[i][5:0];
                        end
                        acc      <= '0;
                        edge_idx <= '0;
                        busy     <= 1'b1;
                        state    <= LOAD;
                    end
                end
                LOAD: begin
                    rad      <= radicand;
                    root     <= '0;
                    rem      <= '0;
                    step_cnt <= '0;
                    state    <= SQRT;
                end
                // Restoring square root: two radicand bits enter per cycle.
                SQRT: begin
                    if (shifted >= divisor) begin
                        rem  <= trial[17:0];
                        root <= {root[14:0], 1'b1};
                    end else begin
                        rem  <= shifted[17:0];
                        root <= {root[14:0], 1'b0};
                    end
                    rad      <= {rad[29:0], 2'b00};
                    step_cnt <= step_cnt + 4'd1;
                    if (step_cnt == 4'd15) begin
                        state <= ACC;
                    end
                end
                ACC: begin
                    acc <= acc_sum;
                    if (edge_idx == 6'd63) begin
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        length <= acc_sum;
                        if (acc_sum < best) begin
                            best     <= acc_sum;
                            improved <= 1'b1;
                        end
                        state <= DONE;
                    end else begin
                        edge_idx <= edge_idx + 6'd1;
                        state    <= LOAD;
                    end
                end
                DONE: begin
                    done     <= 1'b0;
                    improved <= 1'b0;
                    edge_idx <= '0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tour_length.sv
// Self-checking bench for tour_length: fixed tour table, snapshot, busy-start,
// reset abort and randomized tours checked against an arithmetic model.
module tb_tour_length;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [63:0][31:0] xs, ys, path;
    logic              busy, done, improved;
    logic [31:0]       length, best;

    int     n_checks = 0;
    int     n_fail   = 0;
    int     cyc;
    longint model_best;

    tour_length dut (
        .clk(clk), .rst(rst), .xs(xs), .ys(ys), .path(path), .start(start),
        .busy(busy), .done(done), .length(length), .best(best), .improved(improved)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          scene;
        int          vx;
        int          vy;
        bit          hi_bit;
        logic [31:0] exp_len;
        logic [31:0] exp_best;
        bit          exp_imp;
    } vec_t;

    vec_t vecs[7];

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic longint isqrt(input longint r);
        longint lo = 0, hi = 65536, mid;
        while (hi - lo > 1) begin
            mid = (lo + hi) / 2;
            if (mid * mid <= r) lo = mid; else hi = mid;
        end
        return lo;
    endfunction

    // Reference: sum of floor(sqrt(dx^2+dy^2)) around the closed tour.
    function automatic longint model_len(input logic [63:0][31:0] x, input logic [63:0][31:0] y,
                                         input logic [63:0][31:0] p);
        longint total = 0;
        for (int i = 0; i < 64; i++) begin
            int a = int'(p[i][5:0]);
            int b = int'(p[(i + 1) % 64][5:0]);
            longint ddx = longint'(x[a][14:0]) - longint'(x[b][14:0]);
            longint ddy = longint'(y[a][14:0]) - longint'(y[b][14:0]);
            total += isqrt(ddx * ddx + ddy * ddy);
        end
        return total;
    endfunction

    task automatic applyStimulus(input int scene, input int vx, input int vy, input bit hi_bit);
        for (int i = 0; i < 64; i++) begin
            path[i] = i;
            xs[i]   = 0;
            ys[i]   = 0;
            if (scene == 0) xs[i] = 10 * i;
        end
        if (scene == 1) begin
            xs[1] = 10; xs[2] = 10; ys[2] = 10; ys[3] = 10;
        end
        if (scene == 2) begin
            xs[1] = vx; ys[1] = vy;
        end
        if (hi_bit) xs[1][20] = 1'b1;
    endtask

    task automatic random_tour(input bit extreme);
        logic [31:0] t;
        int perm[64];
        for (int i = 0; i < 64; i++) perm[i] = i;
        for (int i = 63; i > 0; i--) begin
            int j = $urandom_range(i, 0);
            int s = perm[i];
            perm[i] = perm[j];
            perm[j] = s;
        end
        for (int i = 0; i < 64; i++) begin
            t = $urandom();
            path[i] = {t[31:6], 6'(perm[i])};
            t = $urandom();
            xs[i] = extreme ? ((i % 2 == 1) ? 32'h0000_7FFF : 32'h0) : t;
            t = $urandom();
            ys[i] = extreme ? ((i % 2 == 1) ? 32'hFFFF_FFFF : 32'h8000) : t;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic start_eval();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc   = 1;
    endtask

    task automatic wait_done(input string name, input logic [31:0] exp_len,
                             input logic [31:0] exp_best, input bit exp_imp);
        bit busy_ok = 1'b1;
        while (done !== 1'b1 && cyc < 1300) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            step();
        end
        checkOutput({name, " latency"}, cyc, 1153);
        checkOutput({name, " busy_during"}, busy_ok, 1);
        checkOutput({name, " busy_at_done"}, busy, 0);
        checkOutput({name, " length"}, length, exp_len);
        checkOutput({name, " best"}, best, exp_best);
        checkOutput({name, " improved"}, improved, exp_imp);
    endtask

    task automatic wait_done_model(input string name, input longint exp_len);
        bit     imp = exp_len < model_best;
        if (imp) model_best = exp_len;
        wait_done(name, 32'(exp_len), 32'(model_best), imp);
    endtask

    task automatic end_pulse(input string name);
        step();
        checkOutput({name, " done_pulse"}, done, 0);
        checkOutput({name, " improved_pulse"}, improved, 0);
    endtask

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout expected finish");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        longint exp_a, exp_b;
        logic [31:0] tmp;
        bit quiet;

        vecs[0] = '{0, 0, 0, 1'b0, 32'd1260, 32'd1260, 1'b1};
        vecs[1] = '{1, 0, 0, 1'b0, 32'd40,   32'd40,   1'b1};
        vecs[2] = '{0, 0, 0, 1'b0, 32'd1260, 32'd40,   1'b0};
        vecs[3] = '{2, 1, 1, 1'b0, 32'd2,    32'd2,    1'b1};
        vecs[4] = '{2, 3, 4, 1'b0, 32'd10,   32'd2,    1'b0};
        vecs[5] = '{2, 3, 4, 1'b1, 32'd10,   32'd2,    1'b0};
        vecs[6] = '{2, 1, 1, 1'b1, 32'd2,    32'd2,    1'b0};

        rst = 1'b1; start = 1'b0; xs = '0; ys = '0; path = '0; cyc = 0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset busy", busy, 0);
        checkOutput("reset done", done, 0);
        checkOutput("reset length", length, 0);
        checkOutput("reset best", best, 32'hFFFF_FFFF);
        rst = 1'b0;
        step();

        for (int v = 0; v < 7; v++) begin
            applyStimulus(vecs[v].scene, vecs[v].vx, vecs[v].vy, vecs[v].hi_bit);
            start_eval();
            wait_done($sformatf("vec%0d", v), vecs[v].exp_len, vecs[v].exp_best, vecs[v].exp_imp);
            end_pulse($sformatf("vec%0d", v));
        end
        model_best = 2;

        // Path changes after the accept cycle must not leak into the evaluation.
        random_tour(1'b0);
        for (int i = 0; i < 64; i++) path[i] = i;
        exp_a = model_len(xs, ys, path);
        start_eval();
        while (cyc < 3) step();
        tmp = path[5]; path[5] = path[40]; path[40] = tmp;
        exp_b = model_len(xs, ys, path);
        wait_done_model("snap_identity", exp_a);
        end_pulse("snap_identity");
        start_eval();
        wait_done_model("snap_swapped", exp_b);
        end_pulse("snap_swapped");

        // Starts while busy and in DONE are dropped, not queued.
        random_tour(1'b0);
        exp_a = model_len(xs, ys, path);
        start_eval();
        while (cyc < 500) step();
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done_model("busy_start", exp_a);
        start = 1'b1;
        step();
        start = 1'b0;
        quiet = 1'b1;
        for (int k = 0; k < 40; k++) begin
            if (busy !== 1'b0 || done !== 1'b0) quiet = 1'b0;
            step();
        end
        checkOutput("busy_start no_restart", quiet, 1);

        // Reset mid-run aborts and restores best.
        random_tour(1'b0);
        exp_a = model_len(xs, ys, path);
        start_eval();
        while (cyc < 600) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checkOutput("midreset busy", busy, 0);
        checkOutput("midreset length", length, 0);
        checkOutput("midreset best", best, 32'hFFFF_FFFF);
        checkOutput("midreset done", done, 0);
        model_best = 64'hFFFF_FFFF;
        start_eval();
        wait_done_model("after_reset", exp_a);
        end_pulse("after_reset");

        // Randomized tours, the first one at the largest possible radicand.
        for (int r = 0; r < 5; r++) begin
            random_tour(r == 0);
            exp_a = model_len(xs, ys, path);
            start_eval();
            wait_done_model($sformatf("rand%0d", r), exp_a);
            end_pulse($sformatf("rand%0d", r));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
